seq_mult_param: RTL
===================

// Module: seq_mult_param
// PURPOSE
//  Parametrised sequential shift-add multiplier: control FSM plus A/B/X datapath in one block.
//  Successor to the fixed 8-bit, 18-state unrolled controller.
//  A counter-driven 4-state FSM, a selectable signed/unsigned mode and a latched multiplicand.
//  Sits between the switch/button input sync and the hex-display drivers in the lab top level.
// PARAMETERS
//  WIDTH   8  operand width in bits (>=2); product is 2*WIDTH bits = {Aval,Bval}
//  SIGNED  1  1 = two's-complement (final-step subtract), 0 = unsigned (X is carry)
// PORTS
//  Clk           in   1      rising-edge clock
//  Reset_n       in   1      async active-low reset
//  Run           in   1      level; start multiply when high in IDLE
//  ClearA_LoadB  in   1      level; in IDLE: A<=0, X<=0, B<=Din
//  Din           in   WIDTH  multiplicand S (latched at start) / multiplier load value
//  Aval          out  WIDTH  A register (product upper half)
//  Bval          out  WIDTH  B register (product lower half / multiplier)
//  X             out  1      extension bit (sign in SIGNED=1, carry in SIGNED=0)
//  Busy          out  1      high in ADD or SHIFT
//  Done          out  1      high in HOLD
// BEHAVIOUR
//  - Reset (Reset_n=0, async): state=IDLE, A=0, B=0, X=0, Sreg=0, cnt=0, Busy=0, Done=0.
//  - State register: {IDLE, ADD, SHIFT, HOLD}.
//  - Counter: cnt, $clog2(WIDTH) bits, counts completed shifts. M = B[0].
//  - IDLE
//    - Run=1: Sreg<=Din, A<=0, X<=0, cnt<=0, ->ADD. B is kept, so a repeat Run multiplies
//      the previous low half by the new Din.
//    - Else if ClearA_LoadB=1: A<=0, X<=0, B<=Din.
//    - Run has priority over ClearA_LoadB on the same edge.
//  - ADD (1 cycle), M=1, {X,A} is WIDTH+1 bits:
//    - SIGNED=1, cnt==WIDTH-1: {X,A} <= sext(A) - sext(Sreg).
//    - SIGNED=1, other cnt: {X,A} <= sext(A) + sext(Sreg).
//    - SIGNED=0: {X,A} <= {1'b0,A} + {1'b0,Sreg}.
//    - M=0: registers hold. Always ->SHIFT.
//  - SHIFT (1 cycle): A <= {X, A[W-1:1]}, B <= {A[0], B[W-1:1]}.
//    - X holds (SIGNED=1); X <= 0 (SIGNED=0).
//    - cnt==WIDTH-1 -> HOLD, else cnt<=cnt+1, ->ADD.
//  - HOLD: registers frozen, Done=1. Run=0 -> IDLE; Run held high stays in HOLD (no auto-restart).
//  - Latency: exactly 2*WIDTH edges after the edge leaving IDLE, Done=1 and {A,B} = product.
//  - Inputs ignored in ADD/SHIFT/HOLD: ClearA_LoadB and Din changes have no effect
//    (Sreg protects the multiplicand).
//  - Reset_n low mid-operation: immediate return to reset values; no partial result retained.
//  - Outputs are direct register values (Moore); Busy/Done decoded from state only, glitch-free.
//  - Arithmetic width: sext(v) = {v[W-1], v}. Signed result is exact for all operand pairs
//    including -2^(W-1) * -2^(W-1).
// TESTING
//  1 W=8,S=1: load B=0x07, Run with Din=0xFD (-3) -> after 16 cycles Done=1, A=0xFF, B=0xEB, X=1 (-21)
//  2 W=8,S=1: B=0x80, Din=0x80 -> A=0x40, B=0x00, X=0 (+16384); then Din=0x02, Run again -> {A,B}=0x0000
//  3 W=4,S=0: B=0xF, Din=0xF -> A=0xE, B=0x1, X=0 (225); Done exactly 8 edges after start edge
//  4 Mid-op (cycle 5): toggle ClearA_LoadB, change Din -> result unchanged vs case 1; Run held high
//    -> stays HOLD; Run low -> IDLE
//  5 Reset_n pulsed low during SHIFT (async, between edges) -> A=B=X=0, Busy=Done=0 before next edge
//  6 IDLE with Run=1 and ClearA_LoadB=1 same edge -> multiply starts, B not reloaded from Din

Source files
------------

// File: rtl/seq_mult_param_if.sv
// Operand/result bundle for the shift-add multiplier: level controls in,
// product halves and status out.
interface seq_mult_param_if #(
  parameter int WIDTH = 8
);
  logic             Run;
  logic             ClearA_LoadB;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             X;
  logic             Busy;
  logic             Done;

  modport master (
    output Run, ClearA_LoadB, Din,
    input  Aval, Bval, X, Busy, Done
  );

  modport slave (
    input  Run, ClearA_LoadB, Din,
    output Aval, Bval, X, Busy, Done
  );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier: counter-driven IDLE/ADD/SHIFT/HOLD controller
// with A/B/X datapath; product {A,B} after 2*WIDTH edges, signed or unsigned.
module seq_mult_param #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input logic             Clk,
  input logic             Reset_n,
  seq_mult_param_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sreg;
  logic             x;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;

  // One partial-product step on {X,A}. In unsigned mode the extension bit is
  // forced to zero so the top bit of the sum is the carry; in signed mode the
  // final multiplier bit carries negative weight, hence the subtract.
  function automatic logic [WIDTH:0] add_step(
    input logic [WIDTH-1:0] a_in,
    input logic [WIDTH-1:0] s_in,
    input logic             last
  );
    logic signed [WIDTH:0] sa;
    logic signed [WIDTH:0] ss;
    sa = $signed({a_in[WIDTH-1] & SIGNED, a_in});
    ss = $signed({s_in[WIDTH-1] & SIGNED, s_in});
    if (SIGNED && last)
      return $unsigned(sa - ss);
    else
      return $unsigned(sa + ss);
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      x     <= 1'b0;
      sreg  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Run) begin
            sreg  <= bus.Din;
            a     <= '0;
            x     <= 1'b0;
            cnt   <= '0;
            state <= ADD;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else if (bus.ClearA_LoadB) begin
            a <= '0;
            x <= 1'b0;
            b <= bus.Din;
          end
        end

        ADD: begin
          if (b[0])
            {x, a} <= add_step(a, sreg, cnt == LAST);
          state <= SHIFT;
        end

        SHIFT: begin
          a <= {x, a[WIDTH-1:1]};
          b <= {a[0], b[WIDTH-1:1]};
          if (!SIGNED)
            x <= 1'b0;
          if (cnt == LAST) begin
            state <= HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end

        HOLD: begin
          // No auto-restart: Run must drop before another multiply can begin.
          if (!bus.Run) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Aval = a;
  assign bus.Bval = b;
  assign bus.X    = x;
  assign bus.Busy = busy;
  assign bus.Done = done;

endmodule
